// File: rtl/pc_fetch_unit.sv
// Program-counter stage that feeds a registered instruction memory: sequential advance, redirects, stalls, halt at end of memory.
// Optional feature macro: PC_MISALIGN_CHECK_EN (misaligned redirects fault instead of being word-aligned).
module pc_fetch_unit #(
  parameter int          MEM_WORDS = 7,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic signed [31:0] branch_offset,
  input  logic               jump_en,
  input  logic        [31:0] jump_target,
  output logic        [31:0] PC,
  output logic        [31:0] pc_byte,
  output logic               inst_valid,
  output logic               halted,
  output logic               misaligned
);

  typedef enum logic [1:0] {BOOT, RUN, FLUSH, HALT} state_t;

  localparam logic [31:0] LAST_IDX = 32'(MEM_WORDS - 1);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        inst_valid_q, inst_valid_d;
  logic        halted_q, halted_d;
  logic        misaligned_q, misaligned_d;

  logic [31:0] seq_pc;
  logic [31:0] redir_raw;
  logic [31:0] redir_pc;
  logic        redir_bad;

  function automatic logic in_range(input logic [31:0] addr);
    return (addr >> 2) <= LAST_IDX;
  endfunction

  always_comb begin
    seq_pc    = pc_q + 32'd4;
    redir_raw = jump_en ? jump_target : pc_q + $unsigned(branch_offset);
`ifdef PC_MISALIGN_CHECK_EN
    redir_pc  = redir_raw;
    redir_bad = |redir_raw[1:0];
`else
    redir_pc  = redir_raw & ~32'd3;
    redir_bad = 1'b0;
`endif
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_valid_d = inst_valid_q;
    halted_d     = halted_q;
    misaligned_d = misaligned_q;
    case (state_q)
      // BOOT and FLUSH both fetch the word at pc_q and then continue sequentially.
      BOOT, FLUSH: begin
        if (!(state_q == FLUSH && stall)) begin
          inst_valid_d = 1'b1;
          if (in_range(seq_pc)) begin
            pc_d    = seq_pc;
            state_d = RUN;
          end else begin
            state_d  = HALT;
            halted_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (stall) begin
          state_d = RUN;
        end else if (jump_en || branch_taken) begin
          if (redir_bad) begin
            misaligned_d = 1'b1;
            halted_d     = 1'b1;
            inst_valid_d = 1'b0;
            state_d      = HALT;
          end else if (!in_range(redir_pc)) begin
            halted_d     = 1'b1;
            inst_valid_d = 1'b1;
            state_d      = HALT;
          end else begin
            pc_d         = redir_pc;
            inst_valid_d = 1'b0;
            state_d      = FLUSH;
          end
        end else begin
          inst_valid_d = 1'b1;
          if (in_range(seq_pc)) begin
            pc_d = seq_pc;
          end else begin
            halted_d = 1'b1;
            state_d  = HALT;
          end
        end
      end
      HALT: begin
        inst_valid_d = 1'b0;
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= BOOT;
      pc_q         <= RESET_PC;
      inst_valid_q <= 1'b0;
      halted_q     <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_valid_q <= inst_valid_d;
      halted_q     <= halted_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign PC         = {2'b00, pc_q[31:2]};
  assign pc_byte    = pc_q;
  assign inst_valid = inst_valid_q;
  assign halted     = halted_q;
`ifdef PC_MISALIGN_CHECK_EN
  assign misaligned = misaligned_q;
`else
  assign misaligned = 1'b0;
`endif

endmodule
